// File: rtl/frame_writer_pkg.sv
// Shared screen geometry, coordinate types and writer state encoding for the pixel write path.
package frame_writer_pkg;

  localparam int FRAME_WIDTH   = 512;
  localparam int SCREEN_WIDTH  = 512;
  localparam int SCREEN_HEIGHT = 384;

  typedef logic [15:0] ScreenX;
  typedef logic [15:0] ScreenY;

  typedef enum logic [1:0] {
    WsIdle  = 2'd0,
    WsClear = 2'd1,
    WsPass  = 2'd2
  } WriterState;

  function automatic logic [63:0] sat_inc64(input logic [63:0] v);
    return (&v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO holding packed {x, y, color} pixels between the tracer and the BRAM.
module pixel_fifo
  import frame_writer_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int COLOR_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [15:0]           in_x,
  input  logic [15:0]           in_y,
  input  logic [COLOR_BITS-1:0] in_color,
  output logic [15:0]           out_x,
  output logic [15:0]           out_y,
  output logic [COLOR_BITS-1:0] out_color,
  output logic                  full,
  output logic                  empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int IDX_BITS     = $clog2(DEPTH);
  localparam int PAYLOAD_BITS = $bits(ScreenX) + $bits(ScreenY) + COLOR_BITS;

  logic [PAYLOAD_BITS-1:0] r_mem [DEPTH];
  logic [IDX_BITS:0]       r_wptr;
  logic [IDX_BITS:0]       r_rptr;
  logic                    w_do_push;
  logic                    w_do_pop;

  assign count     = r_wptr - r_rptr;
  assign empty     = (r_wptr == r_rptr);
  assign full      = (count == (IDX_BITS + 1)'(DEPTH));
  // A full FIFO refuses pushes even when popped in the same cycle.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  assign {out_x, out_y, out_color} = r_mem[r_rptr[IDX_BITS-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[IDX_BITS-1:0]] <= {in_x, in_y, in_color};
  end

endmodule

// File: rtl/frame_writer.sv
// Pixel write stage: clears the visible region, then streams buffered pixels into BRAM port A
// and publishes per-frame render statistics.
module frame_writer #(
  parameter int FRAME_WIDTH   = frame_writer_pkg::FRAME_WIDTH,
  parameter int SCREEN_WIDTH  = frame_writer_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = frame_writer_pkg::SCREEN_HEIGHT,
  parameter int ADDR_BITS     = 18,
  parameter int COLOR_BITS    = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic [COLOR_BITS-1:0] clear_color,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           in_x,
  input  logic [15:0]           in_y,
  input  logic [COLOR_BITS-1:0] in_color,
  output logic                  bram_we,
  output logic [ADDR_BITS-1:0]  bram_addr,
  output logic [COLOR_BITS-1:0] bram_din,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  finished,
  output logic [63:0]           frame_cycles,
  output logic [31:0]           write_count,
  output logic [31:0]           drop_count
);

  localparam logic [1:0] ST_IDLE  = frame_writer_pkg::WsIdle;
  localparam logic [1:0] ST_CLEAR = frame_writer_pkg::WsClear;
  localparam logic [1:0] ST_PASS  = frame_writer_pkg::WsPass;

  localparam int                   LVL_BITS   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_BITS-1:0]  LVL_FULL   = LVL_BITS'(FIFO_DEPTH);
  localparam logic [15:0]          LAST_X     = 16'(SCREEN_WIDTH - 1);
  localparam logic [15:0]          LAST_Y     = 16'(SCREEN_HEIGHT - 1);
  localparam logic [ADDR_BITS-1:0] ROW_STRIDE = ADDR_BITS'(FRAME_WIDTH);
  localparam bit                   STRIDE_POW2 = (FRAME_WIDTH & (FRAME_WIDTH - 1)) == 0;

  logic [1:0]            r_state;
  logic [COLOR_BITS-1:0] r_clear_color;
  logic [15:0]           r_clr_x;
  logic [15:0]           r_clr_y;
  logic [ADDR_BITS-1:0]  r_clr_base;
  logic [63:0]           r_cycles;
  logic [63:0]           r_frame_cycles;
  logic [31:0]           r_write_count;
  logic [31:0]           r_drop_count;
  logic                  r_finished;
  logic                  r_we;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [COLOR_BITS-1:0] r_din;
  logic                  r_frame_done;
  logic                  r_in_ready;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_flush;
  logic                  w_full;
  logic                  w_empty;
  logic [LVL_BITS-1:0]   w_count;
  logic [LVL_BITS-1:0]   w_level_d;
  logic [15:0]           w_head_x;
  logic [15:0]           w_head_y;
  logic [COLOR_BITS-1:0] w_head_color;
  logic [ADDR_BITS-1:0]  w_head_row;
  logic [ADDR_BITS-1:0]  w_head_addr;
  logic                  w_head_in_range;
  logic                  w_done;
  logic                  w_clearing;
  logic [15:0]           w_cx;
  logic [15:0]           w_cy;
  logic [ADDR_BITS-1:0]  w_cbase;
  logic [COLOR_BITS-1:0] w_ccolor;
  logic                  w_clr_last;
  logic [1:0]            w_state_d;

  pixel_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .COLOR_BITS (COLOR_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (w_flush),
    .push      (w_push),
    .pop       (w_pop),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_color  (in_color),
    .out_x     (w_head_x),
    .out_y     (w_head_y),
    .out_color (w_head_color),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  if (STRIDE_POW2) begin : g_row_shift
    assign w_head_row = ADDR_BITS'(w_head_y) << $clog2(FRAME_WIDTH);
  end else begin : g_row_mul
    assign w_head_row = ADDR_BITS'(w_head_y) * ROW_STRIDE;
  end

  // frame_start emits the first clear write itself, so the sweep starts from (0, 0) that cycle.
  assign w_clearing = frame_start || (r_state == ST_CLEAR);
  assign w_cx       = frame_start ? 16'd0 : r_clr_x;
  assign w_cy       = frame_start ? 16'd0 : r_clr_y;
  assign w_cbase    = frame_start ? '0 : r_clr_base;
  assign w_ccolor   = frame_start ? clear_color : r_clear_color;
  assign w_clr_last = (w_cx == LAST_X) && (w_cy == LAST_Y);

  assign w_head_in_range = (w_head_x <= LAST_X) && (w_head_y <= LAST_Y);
  assign w_head_addr     = w_head_row + ADDR_BITS'(w_head_x);
  assign w_pop           = (r_state == ST_PASS) && !w_empty && !frame_start;
  assign w_done          = w_pop && (w_head_x == LAST_X) && (w_head_y == LAST_Y);
  assign w_flush         = frame_start || w_done;
  assign w_push          = in_valid && r_in_ready && !frame_start;

  always_comb begin
    w_state_d = r_state;
    if (w_clearing) begin
      w_state_d = w_clr_last ? ST_PASS : ST_CLEAR;
    end else if (w_done) begin
      w_state_d = ST_IDLE;
    end
  end

  always_comb begin
    w_level_d = w_count + LVL_BITS'(w_push) - LVL_BITS'(w_pop);
    if (w_flush) w_level_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_clear_color  <= '0;
      r_clr_x        <= '0;
      r_clr_y        <= '0;
      r_clr_base     <= '0;
      r_cycles       <= '0;
      r_frame_cycles <= '0;
      r_write_count  <= '0;
      r_drop_count   <= '0;
      r_finished     <= 1'b0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_din          <= '0;
      r_frame_done   <= 1'b0;
      r_in_ready     <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_frame_done <= w_done;
      r_in_ready   <= (w_state_d != ST_IDLE) && (w_level_d != LVL_FULL);
      r_we         <= 1'b0;

      if (w_clearing) begin
        r_we   <= 1'b1;
        r_addr <= w_cbase + ADDR_BITS'(w_cx);
        r_din  <= w_ccolor;
        if (w_cx == LAST_X) begin
          r_clr_x    <= 16'd0;
          r_clr_y    <= w_cy + 16'd1;
          r_clr_base <= w_cbase + ROW_STRIDE;
        end else begin
          r_clr_x    <= w_cx + 16'd1;
          r_clr_base <= w_cbase;
          r_clr_y    <= w_cy;
        end
      end else if (w_pop && w_head_in_range) begin
        r_we   <= 1'b1;
        r_addr <= w_head_addr;
        r_din  <= w_head_color;
      end

      if (frame_start) begin
        r_clear_color <= clear_color;
        r_cycles      <= 64'd1;
        r_write_count <= '0;
        r_drop_count  <= '0;
        r_finished    <= 1'b0;
      end else begin
        if (r_state != ST_IDLE) r_cycles <= frame_writer_pkg::sat_inc64(r_cycles);
        if (w_pop) begin
          if (w_head_in_range) r_write_count <= r_write_count + 32'd1;
          else                 r_drop_count  <= r_drop_count + 32'd1;
        end
        // The completion cycle itself is included in the latched render time.
        if (w_done) begin
          r_frame_cycles <= frame_writer_pkg::sat_inc64(r_cycles);
          r_finished     <= 1'b1;
        end
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign bram_we      = r_we;
  assign bram_addr    = r_addr;
  assign bram_din     = r_din;
  assign busy         = (r_state != ST_IDLE);
  assign frame_done   = r_frame_done;
  assign finished     = r_finished;
  assign frame_cycles = r_frame_cycles;
  assign write_count  = r_write_count;
  assign drop_count   = r_drop_count;

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer on a 4x3 screen with an 8-pixel row stride and a 4-entry FIFO.
module tb_frame_writer;

  localparam int FW = 8;
  localparam int SW = 4;
  localparam int SH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [15:0] clear_color = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic [15:0] in_y = '0;
  logic [15:0] in_color = '0;
  logic        bram_we;
  logic [17:0] bram_addr;
  logic [15:0] bram_din;
  logic        busy;
  logic        frame_done;
  logic        finished;
  logic [63:0] frame_cycles;
  logic [31:0] write_count;
  logic [31:0] drop_count;

  frame_writer #(
    .FRAME_WIDTH   (FW),
    .SCREEN_WIDTH  (SW),
    .SCREEN_HEIGHT (SH),
    .ADDR_BITS     (18),
    .COLOR_BITS    (16),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .clear_color  (clear_color),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_color     (in_color),
    .bram_we      (bram_we),
    .bram_addr    (bram_addr),
    .bram_din     (bram_din),
    .busy         (busy),
    .frame_done   (frame_done),
    .finished     (finished),
    .frame_cycles (frame_cycles),
    .write_count  (write_count),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected BRAM write stream; cyc < 0 means "in order, exact cycle not pinned".
  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
    int          cyc;
    bit          last;
    bit          pixel;
  } wr_t;

  wr_t     expq[$];
  bit      m_active = 0;
  bit      m_finished = 0;
  int      m_wc_seen = 0;
  int      m_wc_acc = 0;
  int      m_dc_acc = 0;
  longint  m_fc = 0;
  int      m_start = 0;

  always @(negedge clk) begin
    bit  last_now;
    wr_t e;
    last_now = 0;
    if (bram_we === 1'b1) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_write: got write addr %0h data %0h, expected none (cycle %0d)",
                 bram_addr, bram_din, cyc);
      end else begin
        e = expq.pop_front();
        chk("write_addr", 64'(bram_addr), 64'(e.addr));
        chk("write_data", 64'(bram_din), 64'(e.data));
        if (e.cyc >= 0) chk("write_cycle", 64'(cyc), 64'(e.cyc));
        if (e.pixel) m_wc_seen++;
        last_now = e.last;
      end
    end else if (expq.size() > 0 && expq[0].cyc >= 0 && expq[0].cyc <= cyc) begin
      n_checks++;
      n_errors++;
      $display("FAIL missing_write: got no write, expected addr %0h at cycle %0d",
               expq[0].addr, expq[0].cyc);
      void'(expq.pop_front());
    end
    if (last_now) begin
      m_active   = 0;
      m_finished = 1;
      m_fc       = longint'(cyc - m_start);
      expq.delete();
    end
    chk("busy", 64'(busy), 64'(m_active));
    chk("frame_done", 64'(frame_done), 64'(last_now));
    chk("finished", 64'(finished), 64'(m_finished));
    chk("frame_cycles", frame_cycles, 64'(m_fc));
    chk("write_count", 64'(write_count), 64'(m_wc_seen));
    if (!m_active) chk("in_ready_idle", 64'(in_ready), 64'd0);

    // Update the model with what the coming clock edge will sample.
    if (rst) begin
      expq.delete();
      m_active = 0; m_finished = 0; m_wc_seen = 0; m_wc_acc = 0; m_dc_acc = 0; m_fc = 0;
    end else if (frame_start) begin
      expq.delete();
      m_start = cyc;
      for (int y = 0; y < SH; y++)
        for (int x = 0; x < SW; x++)
          expq.push_back('{addr: 18'(y * FW + x), data: clear_color,
                           cyc: cyc + 1 + y * SW + x, last: 0, pixel: 0});
      m_active = 1; m_finished = 0; m_wc_seen = 0; m_wc_acc = 0; m_dc_acc = 0;
    end else if (in_valid && in_ready) begin
      if (int'(in_x) < SW && int'(in_y) < SH) begin
        expq.push_back('{addr: 18'(int'(in_y) * FW + int'(in_x)), data: in_color, cyc: -1,
                         last: (int'(in_x) == SW - 1 && int'(in_y) == SH - 1), pixel: 1});
        m_wc_acc++;
      end else begin
        m_dc_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge of cycle c.
  task automatic at_cycle(input int c);
    while (cyc < c) tick();
    @(negedge clk);
  endtask

  task automatic start_frame(input logic [15:0] color, output int t0);
    frame_start = 1'b1;
    clear_color = color;
    t0 = cyc;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] c,
                      output int acc_cyc);
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    in_color = c;
    acc_cyc = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) acc_cyc = cyc;
      tick();
      if (acc_cyc >= 0) break;
    end
    in_valid = 1'b0;
    if (acc_cyc < 0) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  int t1, t2, t3, t4, ta, tb, tc;
  int acc[6];
  int n_in_clear;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("reset_we", 64'(bram_we), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_drop", 64'(drop_count), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Clear sweep.
    start_frame(16'h0ABC, t1);
    at_cycle(t1 + 1);
    chk("clear_first_we", 64'(bram_we), 64'd1);
    chk("clear_first_addr", 64'(bram_addr), 64'd0);
    chk("clear_first_data", 64'(bram_din), 64'h0ABC);
    at_cycle(t1 + 12);
    chk("clear_last_addr", 64'(bram_addr), 64'd19);
    at_cycle(t1 + 13);
    chk("clear_over_we", 64'(bram_we), 64'd0);
    chk("pass_busy", 64'(busy), 64'd1);
    tick();

    // Pass latency.
    send(16'd1, 16'd2, 16'h0F0F, ta);
    at_cycle(ta + 1);
    chk("latency_t1_we", 64'(bram_we), 64'd0);
    at_cycle(ta + 2);
    chk("latency_we", 64'(bram_we), 64'd1);
    chk("latency_addr", 64'(bram_addr), 64'd17);
    chk("latency_data", 64'(bram_din), 64'h0F0F);
    chk("latency_wc", 64'(write_count), 64'd1);
    tick();

    // Out-of-range drops.
    send(16'd4, 16'd0, 16'h1111, tb);
    send(16'd0, 16'd3, 16'h2222, tb);
    at_cycle(cyc + 4);
    chk("drop_count", 64'(drop_count), 64'd2);
    chk("drop_model", 64'(drop_count), 64'(m_dc_acc));
    chk("drop_wc", 64'(write_count), 64'd1);
    tick();

    // Completion.
    send(16'd3, 16'd2, 16'h1234, tc);
    at_cycle(tc + 2);
    chk("done_we", 64'(bram_we), 64'd1);
    chk("done_addr", 64'(bram_addr), 64'd19);
    chk("done_pulse", 64'(frame_done), 64'd1);
    chk("done_finished", 64'(finished), 64'd1);
    chk("done_cycles", frame_cycles, 64'(tc + 2 - t1));
    chk("done_wc", 64'(write_count), 64'd2);
    at_cycle(tc + 3);
    chk("done_pulse_once", 64'(frame_done), 64'd0);
    chk("done_finished_hold", 64'(finished), 64'd1);
    tick();
    in_valid = 1'b1;
    in_x = 16'd0;
    in_y = 16'd0;
    in_color = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("after_done_ready", 64'(in_ready), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    tick();

    // Backpressure during the clear sweep.
    start_frame(16'h1111, t2);
    for (int i = 0; i < 6; i++)
      send(16'(i % 4), 16'(i / 4), 16'hA000 + 16'(i), acc[i]);
    n_in_clear = 0;
    for (int i = 0; i < 6; i++) if (acc[i] >= 0 && acc[i] <= t2 + 11) n_in_clear++;
    chk("bp_accepted_in_clear", 64'(n_in_clear), 64'd4);
    chk("bp_first_accept", 64'(acc[0]), 64'(t2 + 1));
    at_cycle(t2 + 30);
    chk("bp_wc", 64'(write_count), 64'd6);
    chk("bp_all_written", 64'(expq.size()), 64'd0);
    tick();

    // Restart mid-PASS with three pixels queued.
    start_frame(16'h2222, t3);
    send(16'd0, 16'd0, 16'hB000, ta);
    send(16'd1, 16'd1, 16'hB001, ta);
    send(16'd2, 16'd2, 16'hB002, ta);
    at_cycle(t3 + 11);
    tick();
    start_frame(16'h3333, t4);
    at_cycle(t4 + 1);
    chk("restart_addr", 64'(bram_addr), 64'd0);
    chk("restart_data", 64'(bram_din), 64'h3333);
    chk("restart_wc", 64'(write_count), 64'd0);
    at_cycle(t4 + 4);
    tick();

    // Reset mid-CLEAR.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_we", 64'(bram_we), 64'd0);
    chk("rst_addr", 64'(bram_addr), 64'd0);
    chk("rst_din", 64'(bram_din), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_cycles", frame_cycles, 64'd0);
    chk("rst_wc", 64'(write_count), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
